// File: rtl/uart_frame_router.sv
// Framed-byte router: parses SOF/CMD/LEN/payload/CSUM frames from a UART byte
// stream and forwards payload through a shared channel-tagged FIFO.
module uart_frame_router #(
  parameter int N_CH    = 2,
  parameter int DEPTH   = 16,
  parameter int CSUM_EN = 1,
  parameter int TO_CYC  = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       out_data,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [7:0]       cmd,
  output logic [15:0]      rx_cnt,
  output logic             frame_done,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic             busy
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int TW   = $clog2(TO_CYC + 1);
  localparam logic [7:0] SOF_BYTE = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN_H   = 3'd2,
    ST_LEN_L   = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5
  } state_t;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Error priority: overflow > bad channel > checksum.
  function automatic logic [2:0] err_pick(input logic ovf, input logic bad, input logic csum);
    logic [2:0] code;
    if (ovf) begin
      code = 3'd4;
    end else if (bad) begin
      code = 3'd2;
    end else if (csum) begin
      code = 3'd1;
    end else begin
      code = 3'd0;
    end
    return code;
  endfunction

  state_t              state_r;
  logic [7:0]          cmd_r;
  logic [7:0]          len_h_r;
  logic [15:0]         len_r;
  logic [15:0]         rx_cnt_r;
  logic [7:0]          csum_r;
  logic                bad_ch_r;
  logic                ovf_r;
  logic                csum_bad_r;
  logic                done_r;
  logic                err_r;
  logic [2:0]          err_code_r;
  logic [TW-1:0]       idle_cnt_r;

  logic [CH_W+7:0]     mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;

  logic                empty_s;
  logic                full_s;
  logic [CH_W-1:0]     head_ch_s;
  logic [7:0]          head_data_s;
  logic [N_CH-1:0]     out_valid_s;
  logic                pop_s;
  logic                pay_s;
  logic                push_s;
  logic                drop_s;
  logic                mism_s;
  logic                timeout_s;

  // FIFO status, head decode, push/pop/drop qualification.
  always_comb begin
    empty_s     = (count_r == {(AW+1){1'b0}});
    full_s      = (count_r == (AW+1)'(DEPTH));
    {head_ch_s, head_data_s} = mem_r[rd_ptr_r];
    out_valid_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      out_valid_s[i] = !empty_s && (head_ch_s == CH_W'(i));
    end
    pop_s     = |(out_valid_s & out_ready);
    pay_s     = rx_valid && (state_r == ST_PAYLOAD) && !bad_ch_r;
    push_s    = pay_s && (!full_s || pop_s);
    drop_s    = pay_s && full_s && !pop_s;
    mism_s    = (rx_data != csum_r);
    timeout_s = (state_r != ST_IDLE) && !rx_valid && (idle_cnt_r == TW'(TO_CYC - 1));
  end

  assign out_valid  = out_valid_s;
  assign out_data   = empty_s ? 8'h00 : head_data_s;
  assign busy       = (state_r != ST_IDLE) || !empty_s;
  assign cmd        = cmd_r;
  assign rx_cnt     = rx_cnt_r;
  assign frame_done = done_r;
  assign frame_err  = err_r;
  assign err_code   = err_code_r;

  // FIFO storage; contents are don't-care while the occupancy count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_r[CH_W-1:0], rx_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame parser FSM with registered status outputs and inter-byte timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cmd_r      <= 8'h00;
      len_h_r    <= 8'h00;
      len_r      <= 16'h0000;
      rx_cnt_r   <= 16'h0000;
      csum_r     <= 8'h00;
      bad_ch_r   <= 1'b0;
      ovf_r      <= 1'b0;
      csum_bad_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 3'd0;
      idle_cnt_r <= {TW{1'b0}};
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (rx_valid || (state_r == ST_IDLE) || timeout_s) begin
        idle_cnt_r <= {TW{1'b0}};
      end else begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end

      if (timeout_s) begin
        err_r      <= 1'b1;
        err_code_r <= 3'd3;
        state_r    <= ST_IDLE;
      end else if (rx_valid) begin
        case (state_r)
          ST_IDLE: begin
            if (rx_data == SOF_BYTE) begin
              state_r    <= ST_CMD;
              rx_cnt_r   <= 16'h0000;
              err_code_r <= 3'd0;
              bad_ch_r   <= 1'b0;
              ovf_r      <= 1'b0;
              csum_bad_r <= 1'b0;
              csum_r     <= 8'h00;
            end
          end
          ST_CMD: begin
            cmd_r    <= rx_data;
            bad_ch_r <= ({1'b0, rx_data[CH_W-1:0]} >= (CH_W+1)'(N_CH));
            csum_r   <= csum_step(csum_r, rx_data);
            state_r  <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len_h_r <= rx_data;
            csum_r  <= csum_step(csum_r, rx_data);
            state_r <= ST_LEN_L;
          end
          ST_LEN_L: begin
            len_r  <= {len_h_r, rx_data};
            csum_r <= csum_step(csum_r, rx_data);
            if ({len_h_r, rx_data} != 16'h0000) begin
              state_r <= ST_PAYLOAD;
            end else if (CSUM_EN != 0) begin
              state_r <= ST_CSUM;
            end else begin
              state_r    <= ST_IDLE;
              done_r     <= 1'b1;
              err_r      <= (err_pick(ovf_r, bad_ch_r, csum_bad_r) != 3'd0);
              err_code_r <= err_pick(ovf_r, bad_ch_r, csum_bad_r);
            end
          end
          ST_PAYLOAD: begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
            csum_r   <= csum_step(csum_r, rx_data);
            ovf_r    <= ovf_r | drop_s;
            if (rx_cnt_r + 16'd1 == len_r) begin
              if (CSUM_EN != 0) begin
                state_r <= ST_CSUM;
              end else begin
                state_r    <= ST_IDLE;
                done_r     <= 1'b1;
                err_r      <= (err_pick(ovf_r | drop_s, bad_ch_r, csum_bad_r) != 3'd0);
                err_code_r <= err_pick(ovf_r | drop_s, bad_ch_r, csum_bad_r);
              end
            end
          end
          ST_CSUM: begin
            csum_bad_r <= csum_bad_r | mism_s;
            state_r    <= ST_IDLE;
            done_r     <= 1'b1;
            err_r      <= (err_pick(ovf_r, bad_ch_r, csum_bad_r | mism_s) != 3'd0);
            err_code_r <= err_pick(ovf_r, bad_ch_r, csum_bad_r | mism_s);
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_router.sv
// Self-checking bench for uart_frame_router: a 2-channel instance under random and
// directed frames, plus a 3-channel instance for the out-of-range channel case.
module tb_uart_frame_router;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] out_ready = 2'b00;
  logic [7:0] out_data;
  logic [1:0] out_valid;
  logic [7:0] cmd;
  logic [15:0] rx_cnt;
  logic       frame_done, frame_err, busy;
  logic [2:0] err_code;

  logic [2:0]  out_ready3 = 3'b111;
  logic [7:0]  out_data3, cmd3;
  logic [2:0]  out_valid3, err_code3;
  logic [15:0] rx_cnt3;
  logic        frame_done3, frame_err3, busy3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_frame_router #(.N_CH(2), .DEPTH(16), .CSUM_EN(1), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cmd(cmd), .rx_cnt(rx_cnt), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  uart_frame_router #(.N_CH(3), .DEPTH(16), .CSUM_EN(1), .TO_CYC(TO)) dut3 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .cmd(cmd3), .rx_cnt(rx_cnt3), .frame_done(frame_done3), .frame_err(frame_err3),
    .err_code(err_code3), .busy(busy3)
  );

  // Monitor: records every handshake {ch,byte} and status pulses mid-cycle.
  logic [8:0] got_q[$];
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [2:0] last_err = 3'd0;
  int done3 = 0, err3 = 0, valid3_cnt = 0;
  logic [2:0] last_err3 = 3'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if ((out_valid & out_ready) != 2'b00) got_q.push_back({out_valid[1], out_data});
      if (frame_done) done_cnt++;
      if (frame_err) begin err_cnt++; last_err = err_code; end
      if (frame_done && frame_err) both_cnt++;
      if (out_valid3 != 3'b000) valid3_cnt++;
      if (frame_done3) done3++;
      if (frame_err3) begin err3++; last_err3 = err_code3; end
    end
  end

  logic [7:0] pay_q[$];

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
  endtask

  // Reference checksum: XOR of CMD, LEN bytes and payload.
  function automatic logic [7:0] ref_csum(input logic [7:0] c);
    logic [15:0] l;
    logic [7:0] x;
    l = 16'(pay_q.size());
    x = c ^ l[15:8] ^ l[7:0];
    foreach (pay_q[i]) x = x ^ pay_q[i];
    return x;
  endfunction

  task automatic send_frame(input logic [7:0] c, input logic [7:0] cs, input int max_gap);
    logic [15:0] l;
    l = 16'(pay_q.size());
    send_byte(8'h55); gap(max_gap);
    send_byte(c);     gap(max_gap);
    send_byte(l[15:8]); gap(max_gap);
    send_byte(l[7:0]);
    foreach (pay_q[i]) begin gap(max_gap); send_byte(pay_q[i]); end
    gap(max_gap);
    send_byte(cs);
  endtask

  task automatic wait_idle(output bit ok);
    out_ready = 2'b11;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_cmp++; if (cmd !== 8'h00) begin n_bad++; $display("FAIL reset_cmd got=%h exp=00", cmd); end
    n_cmp++; if (rx_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_rx_cnt got=%0d exp=0", rx_cnt); end
    n_cmp++; if ({frame_done, frame_err} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got=%b exp=00", {frame_done, frame_err}); end
    n_cmp++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic run_fixed(input logic [7:0] cs, input logic [2:0] exp_err, input string nm);
    int base, d0, e0, b0;
    bit ok;
    base = got_q.size(); d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
    out_ready = 2'b11;
    pay_q = '{8'hA1, 8'hB2, 8'hC3};
    send_frame(8'h01, cs, 0);
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL %s_done_timing got=%b exp=1", nm, frame_done); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_drain_timeout got=busy exp=idle", nm); end
    n_cmp++; if (got_q.size() - base !== 3) begin n_bad++; $display("FAIL %s_count got=%0d exp=3", nm, got_q.size() - base); end
    for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== {1'b1, pay_q[i]}) begin n_bad++; $display("FAIL %s_byte%0d got=%h exp=%h", nm, i, got_q[base+i], {1'b1, pay_q[i]}); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL %s_done_cnt got=%0d exp=1", nm, done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 !== ((exp_err != 3'd0) ? 1 : 0)) begin n_bad++; $display("FAIL %s_err_cnt got=%0d exp=%0d", nm, err_cnt - e0, (exp_err != 3'd0) ? 1 : 0); end
    n_cmp++; if (err_code !== exp_err) begin n_bad++; $display("FAIL %s_err_code got=%0d exp=%0d", nm, err_code, exp_err); end
    if (exp_err != 3'd0) begin
      n_cmp++; if (both_cnt - b0 !== 1) begin n_bad++; $display("FAIL %s_done_err_together got=%0d exp=1", nm, both_cnt - b0); end
    end
    n_cmp++; if (rx_cnt !== 16'd3) begin n_bad++; $display("FAIL %s_rx_cnt got=%0d exp=3", nm, rx_cnt); end
    n_cmp++; if (cmd !== 8'h01) begin n_bad++; $display("FAIL %s_cmd got=%h exp=01", nm, cmd); end
  endtask

  task automatic test_spec_frame();
    run_fixed(8'hD2, 3'd0, "spec_frame");
  endtask

  task automatic test_bad_csum();
    run_fixed(8'h00, 3'd1, "bad_csum");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      int base, d0, e0, len;
      logic [7:0] c, cs, junk;
      bit corrupt, ok;
      c = 8'($urandom_range(0, 255));
      len = int'($urandom_range(0, 12));
      corrupt = ($urandom_range(0, 2) == 0);
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
      cs = ref_csum(c);
      if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
      base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
      out_ready = 2'($urandom_range(0, 3));
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'h55) junk = 8'h00;
      send_byte(junk);
      send_frame(c, cs, 3);
      wait_idle(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_drain_timeout got=busy exp=idle", f); end
      n_cmp++; if (got_q.size() - base !== len) begin n_bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, got_q.size() - base, len); end
      for (int i = 0; i < len && base + i < got_q.size(); i++) begin
        n_cmp++; if (got_q[base+i] !== {c[0], pay_q[i]}) begin n_bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", f, i, got_q[base+i], {c[0], pay_q[i]}); end
      end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL rand%0d_done got=%0d exp=1", f, done_cnt - d0); end
      n_cmp++; if (err_cnt - e0 !== (corrupt ? 1 : 0)) begin n_bad++; $display("FAIL rand%0d_err got=%0d exp=%0d", f, err_cnt - e0, corrupt ? 1 : 0); end
      n_cmp++; if (err_code !== (corrupt ? 3'd1 : 3'd0)) begin n_bad++; $display("FAIL rand%0d_err_code got=%0d exp=%0d", f, err_code, corrupt ? 1 : 0); end
      n_cmp++; if (rx_cnt !== 16'(len)) begin n_bad++; $display("FAIL rand%0d_rx_cnt got=%0d exp=%0d", f, rx_cnt, len); end
      n_cmp++; if (cmd !== c) begin n_bad++; $display("FAIL rand%0d_cmd got=%h exp=%h", f, cmd, c); end
    end
  endtask

  task automatic test_bad_channel();
    int base, v0, d30, e30, e0;
    bit ok;
    pay_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    base = got_q.size(); v0 = valid3_cnt; d30 = done3; e30 = err3; e0 = err_cnt;
    out_ready = 2'b11;
    send_frame(8'h03, ref_csum(8'h03), 1);
    wait_idle(ok);
    n_cmp++; if (got_q.size() - base !== 4) begin n_bad++; $display("FAIL badch_n2_count got=%0d exp=4", got_q.size() - base); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL badch_n2_err got=%0d exp=0", err_cnt - e0); end
    n_cmp++; if (valid3_cnt - v0 !== 0) begin n_bad++; $display("FAIL badch_n3_pushes got=%0d exp=0", valid3_cnt - v0); end
    n_cmp++; if (done3 - d30 !== 1) begin n_bad++; $display("FAIL badch_n3_done got=%0d exp=1", done3 - d30); end
    n_cmp++; if (err3 - e30 !== 1) begin n_bad++; $display("FAIL badch_n3_err got=%0d exp=1", err3 - e30); end
    n_cmp++; if (last_err3 !== 3'd2) begin n_bad++; $display("FAIL badch_n3_err_code got=%0d exp=2", last_err3); end
    n_cmp++; if (rx_cnt3 !== 16'd4) begin n_bad++; $display("FAIL badch_n3_rx_cnt got=%0d exp=4", rx_cnt3); end
  endtask

  task automatic test_overflow();
    int base, e0;
    bit ok;
    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    base = got_q.size(); e0 = err_cnt;
    out_ready = 2'b00;
    send_frame(8'h01, ref_csum(8'h01), 0);
    idle(2);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL ovf_err got=%0d exp=1", err_cnt - e0); end
    n_cmp++; if (err_code !== 3'd4) begin n_bad++; $display("FAIL ovf_err_code got=%0d exp=4", err_code); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy_held got=%b exp=1", busy); end
    n_cmp++; if (out_valid !== 2'b10) begin n_bad++; $display("FAIL ovf_out_valid got=%b exp=10", out_valid); end
    n_cmp++; if (rx_cnt !== 16'd20) begin n_bad++; $display("FAIL ovf_rx_cnt got=%0d exp=20", rx_cnt); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_drain_timeout got=busy exp=idle"); end
    n_cmp++; if (got_q.size() - base !== 16) begin n_bad++; $display("FAIL ovf_count got=%0d exp=16", got_q.size() - base); end
    for (int i = 0; i < 16 && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== {1'b1, pay_q[i]}) begin n_bad++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got_q[base+i], {1'b1, pay_q[i]}); end
    end
  endtask

  task automatic test_timeout();
    int seen_k, d0, e0, base;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h55);
    send_byte(8'h01);
    seen_k = -1;
    for (int k = 1; k <= 5 * TO; k++) begin
      @(posedge clk); #1;
      if (frame_err) begin seen_k = k; break; end
    end
    #1;
    n_cmp++; if (seen_k !== TO) begin n_bad++; $display("FAIL timeout_latency got=%0d exp=%0d", seen_k, TO); end
    n_cmp++; if (err_code !== 3'd3) begin n_bad++; $display("FAIL timeout_err_code got=%0d exp=3", err_code); end
    idle(2);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL timeout_no_done got=%0d exp=0", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_err_cnt got=%0d exp=1", err_cnt - e0); end
    pay_q = '{8'h11, 8'h22};
    base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
    out_ready = 2'b11;
    send_frame(8'h02, ref_csum(8'h02), 0);
    wait_idle(ok);
    n_cmp++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin n_bad++; $display("FAIL after_timeout_status got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
    n_cmp++; if (got_q.size() - base !== 2) begin n_bad++; $display("FAIL after_timeout_count got=%0d exp=2", got_q.size() - base); end
    for (int i = 0; i < 2 && base + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[base+i] !== {1'b0, pay_q[i]}) begin n_bad++; $display("FAIL after_timeout_byte%0d got=%h exp=%h", i, got_q[base+i], {1'b0, pay_q[i]}); end
    end
  endtask

  task automatic test_len_zero();
    int base, d0, e0;
    pay_q.delete();
    base = got_q.size(); d0 = done_cnt; e0 = err_cnt;
    out_ready = 2'b11;
    send_frame(8'h05, 8'h05, 0);
    idle(2);
    n_cmp++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin n_bad++; $display("FAIL len0_status got=%0d/%0d exp=1/0", done_cnt - d0, err_cnt - e0); end
    n_cmp++; if (got_q.size() - base !== 0) begin n_bad++; $display("FAIL len0_push got=%0d exp=0", got_q.size() - base); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy got=%b exp=0", busy); end
    n_cmp++; if (cmd !== 8'h05) begin n_bad++; $display("FAIL len0_cmd got=%h exp=05", cmd); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    out_ready = 2'b00;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, out_data} !== 10'd0) begin n_bad++; $display("FAIL rstmid_out got=%b/%h exp=00/00", out_valid, out_data); end
    n_cmp++; if (cmd !== 8'h00 || rx_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_cmd_cnt got=%h/%0d exp=00/0", cmd, rx_cnt); end
    n_cmp++; if ({busy, frame_done, frame_err, err_code} !== 6'd0) begin n_bad++; $display("FAIL rstmid_status got=%b exp=000000", {busy, frame_done, frame_err, err_code}); end
    rst = 1'b0;
    idle(1);
    pay_q = '{8'h77};
    base = got_q.size();
    out_ready = 2'b11;
    send_frame(8'h00, 8'h76, 0);
    wait_idle(ok);
    n_cmp++; if (got_q.size() - base !== 1 || (got_q.size() > base && got_q[base] !== 9'h077)) begin n_bad++; $display("FAIL rstmid_recover got=%0d bytes exp=1 byte 077", got_q.size() - base); end
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_bad_csum();
    test_random_frames();
    test_bad_channel();
    test_overflow();
    test_timeout();
    test_len_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
